// File: rtl/arm_ctrl_fsm.sv
// arm_ctrl_fsm: multi-cycle control sequencer for a small ARM-style core.
// It fetches an instruction, checks its condition against the registered
// NZCV flags, and issues single-cycle strobes for execute, memory and
// writeback. It also owns the CPSR flag register and a bus-timeout watchdog.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   run                1 = keep executing, 0 = park in IDLE at the next boundary
//   imem_req/imem_ack  instruction fetch handshake; ir_load latches the IR
//   dec_*              decoder controls for the current instruction
//   alu_flags          ALU NZCV result {N,Z,C,V}
//   dmem_req/dmem_we/dmem_ack  data access handshake
//   rf_we, rf_link_we  register-file write of Rd / R14 (return address)
//   pc_inc, pc_load_branch  PC update strobes (never both in one cycle)
//   flags              registered CPSR NZCV
//   state              current state encoding
//   undef, bus_err     one-cycle error pulses
module arm_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       ir_load,
  input  logic       dec_valid,
  input  logic       dec_reg_write,
  input  logic       dec_mem_read,
  input  logic       dec_mem_write,
  input  logic       dec_branch,
  input  logic       dec_branch_link,
  input  logic       dec_s_bit,
  input  logic [3:0] dec_cond,
  input  logic [3:0] alu_flags,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       rf_we,
  output logic       rf_link_we,
  output logic       pc_inc,
  output logic       pc_load_branch,
  output logic [3:0] flags,
  output logic [2:0] state,
  output logic       undef,
  output logic       bus_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  state_t            state_q, state_d, resume;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic [3:0]        flags_q, flags_d;
  logic              wait_expired;

  // ARM condition-code evaluation on {N,Z,C,V}; 4'hF never reaches here
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cf;
      4'h3:    cond_pass = !cf;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cf && !z;
      4'h9:    cond_pass = !cf || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign state = state_q;
  assign flags = flags_q;

  // This cycle is the MEM_TIMEOUT-th consecutive cycle without an ack
  assign wait_expired = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Any return toward FETCH parks in IDLE instead when run is low
  always_comb begin
    resume = IDLE;
    if (run) resume = FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_cnt_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt;
    flags_d        = flags_q;
    imem_req       = 1'b0;
    ir_load        = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    rf_we          = 1'b0;
    rf_link_we     = 1'b0;
    pc_inc         = 1'b0;
    pc_load_branch = 1'b0;
    undef          = 1'b0;
    bus_err        = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end else if (wait_expired) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end

      DECODE: begin
        if (!dec_valid || dec_cond == 4'hF) begin
          undef   = 1'b1;
          pc_inc  = 1'b1;
          state_d = resume;
        end else if (!cond_pass(dec_cond, flags_q)) begin
          pc_inc  = 1'b1;
          state_d = resume;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (dec_branch) begin
          pc_load_branch = 1'b1;
          rf_link_we     = dec_branch_link;
          state_d        = resume;
        end else if (dec_mem_read || dec_mem_write) begin
          state_d = MEM;
        end else begin
          rf_we  = dec_reg_write;
          pc_inc = 1'b1;
          if (dec_s_bit) flags_d = alu_flags;
          state_d = resume;
        end
      end

      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_write;
        if (dmem_ack) begin
          if (dec_mem_read) begin
            state_d = WB;
          end else begin
            pc_inc  = 1'b1;
            state_d = resume;
          end
        end else if (wait_expired) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end

      WB: begin
        rf_we   = 1'b1;
        pc_inc  = 1'b1;
        state_d = resume;
      end

      default: state_d = IDLE;
    endcase

    // Every state change restarts the watchdog so FETCH/MEM begin at zero
    if (state_d != state_q) wait_cnt_d = '0;
  end

endmodule

// File: doc/arm_ctrl_fsm.md
ARM_CTRL_FSM -- requirements
Module: arm_ctrl_fsm

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, maximum wait cycles for imem_ack/dmem_ack before bus error.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary.
REQ-005 imem_req  out  1  fetch request; imem_ack  in  1  fetch data valid.
REQ-006 ir_load  out  1  latch instruction register.
REQ-007 dec_valid, dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_branch_link, dec_s_bit  in  1 each  decoder controls; dec_cond  in  4  condition field.
REQ-008 alu_flags  in  4  ALU NZCV result {N,Z,C,V}.
REQ-009 dmem_req  out  1, dmem_we  out  1  data access request/write; dmem_ack  in  1  access done.
REQ-010 rf_we  out  1  write Rd; rf_link_we  out  1  write R14 with return address.
REQ-011 pc_inc  out  1  PC <= PC+4; pc_load_branch  out  1  PC <= branch target.
REQ-012 flags  out  4  registered CPSR NZCV.
REQ-013 state  out  3  current state encoding.
REQ-014 undef  out  1, bus_err  out  1  one-cycle error pulses.

Function
REQ-015 States/encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; codes 6-7 SHALL return to IDLE next cycle.
REQ-016 IDLE: all strobes 0; run=1 -> FETCH.
REQ-017 Every transition toward FETCH SHALL go to IDLE instead when run=0 in that cycle.
REQ-018 FETCH: imem_req=1 held until imem_ack; ack cycle: ir_load=1, -> DECODE.
REQ-019 DECODE: dec_valid=0 -> undef=1, pc_inc=1, -> FETCH; condition false -> pc_inc=1, -> FETCH, no other side effect; else -> EXEC.
REQ-020 Condition SHALL follow ARM table on flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1; 4'hF SHALL be treated as dec_valid=0.
REQ-021 EXEC branch: pc_load_branch=1, rf_link_we=dec_branch_link, -> FETCH; flags unchanged.
REQ-022 EXEC with dec_mem_read or dec_mem_write -> MEM, no strobes.
REQ-023 EXEC otherwise (data-processing): rf_we=dec_reg_write, pc_inc=1, flags<=alu_flags at edge iff dec_s_bit=1, -> FETCH.
REQ-024 MEM: dmem_req=1, dmem_we=dec_mem_write, held until dmem_ack; ack with read -> WB; ack with write -> pc_inc=1, -> FETCH.
REQ-025 WB: rf_we=1, pc_inc=1, -> FETCH.
REQ-026 Latency with zero-wait ack SHALL be: data-processing/branch 3 cycles, store 4, load 5, condition-failed 2.
REQ-027 Wait counter SHALL clear on entry to FETCH/MEM, count each no-ack cycle; at MEM_TIMEOUT no-ack cycles: req dropped, bus_err=1, -> IDLE.
REQ-028 Ack in the same cycle the counter reaches MEM_TIMEOUT SHALL win (no bus_err).
REQ-029 Only one of rf_we, pc_inc, pc_load_branch groups per instruction; pc_inc and pc_load_branch SHALL never be 1 together.
REQ-030 Strobes other than imem_req/dmem_req SHALL be single-cycle pulses.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, flags=0, counter=0, all outputs 0, including mid-FETCH/MEM with request pending.
REQ-032 After rst_n rises, first FETCH SHALL begin the cycle after run=1 is sampled.

Verification
REQ-033 ADD (dec_cond=E, reg_write=1, s_bit=0), zero-wait ack -> states 1,2,3,1; rf_we and pc_inc one pulse in EXEC; flags unchanged.
REQ-034 flags=0100, dec_cond=0 (EQ) then dec_cond=1 (NE) -> first reaches EXEC; second pc_inc in DECODE, rf_we never 1.
REQ-035 LDR, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, WB rf_we=1 pc_inc=1; total 8 cycles.
REQ-036 BL -> EXEC pc_load_branch=1, rf_link_we=1, pc_inc=0; CMPS with alu_flags=0110 -> flags=0110, rf_we=0.
REQ-037 imem_ack never asserted -> bus_err pulse after 16 cycles, state IDLE; repeat with ack on cycle 16 -> no bus_err, DECODE.
REQ-038 rst_n low in MEM with dmem_req=1 -> dmem_req=0, state=0, flags=0 before next edge; dec_valid=0 -> undef single pulse.
